// File: rtl/xpar_mailbox_if.sv
// Bus bundle for xpar_mailbox.
// Carries the picoVersat parallel-interface signals (par_addr/par_we/par_out/par_in)
// and the two host-side valid/ready streams (TX: mailbox to host, RX: host to mailbox).
//   master : core + host side (drives addresses, write data, host handshakes)
//   slave  : the mailbox itself
interface xpar_mailbox_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PAR_ADDR_W = 15
);
  logic [PAR_ADDR_W-1:0] par_addr;
  logic                  par_we;
  logic [DATA_W-1:0]     par_out;
  logic [DATA_W-1:0]     par_in;

  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_W-1:0]     tx_data;

  logic                  rx_valid;
  logic                  rx_ready;
  logic [DATA_W-1:0]     rx_data;

  modport master (
    output par_addr, par_we, par_out, tx_ready, rx_valid, rx_data,
    input  par_in, tx_valid, tx_data, rx_ready
  );

  modport slave (
    input  par_addr, par_we, par_out, tx_ready, rx_valid, rx_data,
    output par_in, tx_valid, tx_data, rx_ready
  );
endinterface

// File: rtl/xpar_mailbox.sv
// Host-side mailbox on the picoVersat external parallel interface.
// The core sees a 4-word register window:
//   reg0 STATUS  (r)  bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty,
//                     [8+:FIFO_AW+1] tx_count, [16+:FIFO_AW+1] rx_count
//   reg1 TX_DATA (w)  push to TX FIFO (reads 0)
//   reg2 RX_DATA (r)  RX head (0 if empty); any write pops the head
//   reg3 ERR/CTRL     read: bit0 tx_ovf, bit1 rx_udf, bit2 rx_ovf (sticky)
//                     write: bit0 flush TX, bit1 flush RX, bit2 clear sticky flags
// Ports:
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-low reset
//   bus  : xpar_mailbox_if slave modport (core par_* bus, TX and RX host streams)
module xpar_mailbox #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PAR_ADDR_W = 15,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned FIFO_AW    = 3
) (
  input logic           clk,
  input logic           rst,
  xpar_mailbox_if.slave bus
);

  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam int unsigned CntW  = FIFO_AW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);
  localparam logic [PAR_ADDR_W-3:0] BaseHi = (PAR_ADDR_W-2)'(BASE_ADDR >> 2);

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic       sel;
  logic [1:0] reg_sel;
  logic       wr_en;

  assign sel     = (bus.par_addr[PAR_ADDR_W-1:2] == BaseHi);
  assign reg_sel = bus.par_addr[1:0];
  assign wr_en   = sel & bus.par_we;

  logic tx_wr, rx_rd_req, ctrl_wr;
  logic tx_flush, rx_flush, err_clr;

  assign tx_wr     = wr_en & (reg_sel == 2'd1);
  assign rx_rd_req = wr_en & (reg_sel == 2'd2);
  assign ctrl_wr   = wr_en & (reg_sel == 2'd3);
  assign tx_flush  = ctrl_wr & bus.par_out[0];
  assign rx_flush  = ctrl_wr & bus.par_out[1];
  assign err_clr   = ctrl_wr & bus.par_out[2];

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0]  tx_mem_q [Depth];
  logic [DATA_W-1:0]  tx_mem_d [Depth];
  logic [FIFO_AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [CntW-1:0]    tx_count_q, tx_count_d;

  logic [DATA_W-1:0]  rx_mem_q [Depth];
  logic [DATA_W-1:0]  rx_mem_d [Depth];
  logic [FIFO_AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CntW-1:0]    rx_count_q, rx_count_d;

  // err: bit0 tx_ovf, bit1 rx_udf, bit2 rx_ovf
  logic [2:0]         err_q, err_d;

  logic tx_full, tx_empty, rx_full, rx_empty;

  assign tx_full  = (tx_count_q == CntFull);
  assign tx_empty = (tx_count_q == '0);
  assign rx_full  = (rx_count_q == CntFull);
  assign rx_empty = (rx_count_q == '0);

  // --------------------------------------------------------------------------
  // TX FIFO (core pushes, host pops)
  // --------------------------------------------------------------------------
  logic tx_pop, tx_push, tx_ovf_set;

  assign tx_pop     = !tx_empty & bus.tx_ready;
  // A full FIFO still takes the word when the host frees a slot in the same cycle.
  assign tx_push    = tx_wr & (!tx_full | tx_pop);
  assign tx_ovf_set = tx_wr & tx_full & !tx_pop;

  always_comb begin
    tx_mem_d   = tx_mem_q;
    tx_wptr_d  = tx_wptr_q;
    tx_rptr_d  = tx_rptr_q;
    tx_count_d = tx_count_q;
    if (tx_flush) begin
      tx_wptr_d  = '0;
      tx_rptr_d  = '0;
      tx_count_d = '0;
    end else begin
      if (tx_push) begin
        tx_mem_d[tx_wptr_q] = bus.par_out;
        tx_wptr_d           = tx_wptr_q + 1'b1;
      end
      if (tx_pop) begin
        tx_rptr_d = tx_rptr_q + 1'b1;
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_count_d = tx_count_q + 1'b1;
        2'b01:   tx_count_d = tx_count_q - 1'b1;
        default: tx_count_d = tx_count_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // RX FIFO (host pushes, core pops)
  // --------------------------------------------------------------------------
  logic rx_ready_int, rx_push, rx_pop, rx_udf_set, rx_ovf_set;

  assign rx_ready_int = !rx_full & rst;
  assign rx_push      = bus.rx_valid & rx_ready_int;
  assign rx_pop       = rx_rd_req & !rx_empty;
  assign rx_udf_set   = rx_rd_req & rx_empty;
  assign rx_ovf_set   = bus.rx_valid & rx_full;

  always_comb begin
    rx_mem_d   = rx_mem_q;
    rx_wptr_d  = rx_wptr_q;
    rx_rptr_d  = rx_rptr_q;
    rx_count_d = rx_count_q;
    if (rx_flush) begin
      rx_wptr_d  = '0;
      rx_rptr_d  = '0;
      rx_count_d = '0;
    end else begin
      if (rx_push) begin
        rx_mem_d[rx_wptr_q] = bus.rx_data;
        rx_wptr_d           = rx_wptr_q + 1'b1;
      end
      if (rx_pop) begin
        rx_rptr_d = rx_rptr_q + 1'b1;
      end
      case ({rx_push, rx_pop})
        2'b10:   rx_count_d = rx_count_q + 1'b1;
        2'b01:   rx_count_d = rx_count_q - 1'b1;
        default: rx_count_d = rx_count_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sticky error flags: a set in the same cycle wins over a clear.
  // --------------------------------------------------------------------------
  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = '0;
    end
    if (tx_ovf_set) err_d[0] = 1'b1;
    if (rx_udf_set) err_d[1] = 1'b1;
    if (rx_ovf_set) err_d[2] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_mem_q   <= '{default: '0};
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_count_q <= '0;
      rx_mem_q   <= '{default: '0};
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_count_q <= '0;
      err_q      <= '0;
    end else begin
      tx_mem_q   <= tx_mem_d;
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_count_q <= tx_count_d;
      rx_mem_q   <= rx_mem_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_count_q <= rx_count_d;
      err_q      <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] tx_head, rx_head, status, par_in_c;

  assign tx_head = tx_empty ? '0 : tx_mem_q[tx_rptr_q];
  assign rx_head = rx_empty ? '0 : rx_mem_q[rx_rptr_q];

  always_comb begin
    status              = '0;
    status[0]           = tx_full;
    status[1]           = tx_empty;
    status[2]           = rx_full;
    status[3]           = rx_empty;
    status[8 +: CntW]   = tx_count_q;
    status[16 +: CntW]  = rx_count_q;
  end

  // Reads are side-effect free; pops happen only on writes to reg2.
  always_comb begin
    par_in_c = '0;
    if (sel) begin
      case (reg_sel)
        2'd0:    par_in_c = status;
        2'd2:    par_in_c = rx_head;
        2'd3:    par_in_c = DATA_W'(err_q);
        default: par_in_c = '0;
      endcase
    end
  end

  assign bus.par_in   = par_in_c;
  assign bus.tx_valid = !tx_empty;
  assign bus.tx_data  = tx_head;
  assign bus.rx_ready = rx_ready_int;

endmodule

// File: tb/tb_xpar_mailbox.sv
// Directed self-checking bench for xpar_mailbox.
module tb_xpar_mailbox;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  xpar_mailbox_if #(.DATA_W(32), .PAR_ADDR_W(15)) bus ();

  xpar_mailbox #(
    .DATA_W    (32),
    .PAR_ADDR_W(15),
    .BASE_ADDR (0),
    .FIFO_AW   (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [14:0] addr, input logic [31:0] exp);
    bus.par_addr = addr;
    bus.par_we   = 1'b0;
    #1;
    chk(tag, bus.par_in, exp);
  endtask

  task automatic wr(input logic [14:0] addr, input logic [31:0] data);
    bus.par_addr = addr;
    bus.par_out  = data;
    bus.par_we   = 1'b1;
    tick();
    bus.par_we   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.par_addr = '0;
    bus.par_we   = 1'b0;
    bus.par_out  = '0;
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;

    // Reset
    tick();
    tick();
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_tx_data", bus.tx_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    rd_chk("status_reset", 15'd0, 32'h0000000A);
    rd_chk("err_reset", 15'd3, 32'h0);
    rd_chk("reg1_reads0", 15'd1, 32'h0);
    chk("rx_ready_after_rst", 32'(bus.rx_ready), 32'd1);
    chk("tx_valid_after_rst", 32'(bus.tx_valid), 32'd0);

    // Three TX words, host stalled
    wr(15'd1, 32'h11);
    chk("tx_valid_latency", 32'(bus.tx_valid), 32'd1);
    wr(15'd1, 32'h22);
    wr(15'd1, 32'h33);
    rd_chk("status_tx3", 15'd0, 32'h00000308);
    bus.tx_ready = 1'b1;
    chk("tx_head0", bus.tx_data, 32'h11);
    tick();
    chk("tx_head1", bus.tx_data, 32'h22);
    tick();
    chk("tx_head2", bus.tx_data, 32'h33);
    tick();
    chk("tx_drained_valid", 32'(bus.tx_valid), 32'd0);
    chk("tx_drained_data", bus.tx_data, 32'd0);
    bus.tx_ready = 1'b0;

    // Fill TX and overflow
    for (int i = 0; i < 8; i++) wr(15'd1, 32'h100 + 32'(i));
    rd_chk("status_tx_full", 15'd0, 32'h00000809);
    wr(15'd1, 32'hDEAD);
    rd_chk("err_tx_ovf", 15'd3, 32'h1);
    rd_chk("status_after_ovf", 15'd0, 32'h00000809);
    chk("tx_head_after_ovf", bus.tx_data, 32'h100);
    wr(15'd3, 32'h4);
    rd_chk("err_cleared", 15'd3, 32'h0);

    // Full TX, push and pop in the same cycle
    bus.tx_ready = 1'b1;
    wr(15'd1, 32'h99);
    bus.tx_ready = 1'b0;
    rd_chk("status_push_pop_full", 15'd0, 32'h00000809);
    rd_chk("err_push_pop_full", 15'd3, 32'h0);
    bus.tx_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk("tx_drain_seq", bus.tx_data, 32'h100 + 32'(i));
      tick();
    end
    chk("tx_drain_last", bus.tx_data, 32'h99);
    tick();
    chk("tx_drain_empty", 32'(bus.tx_valid), 32'd0);
    bus.tx_ready = 1'b0;

    // RX path
    bus.rx_valid = 1'b1;
    bus.rx_data  = 32'hA5A5A5A5;
    tick();
    rd_chk("rx_latency", 15'd2, 32'hA5A5A5A5);
    bus.rx_data  = 32'h5A5A5A5A;
    tick();
    bus.rx_valid = 1'b0;
    rd_chk("status_rx2", 15'd0, 32'h00020002);
    rd_chk("rx_head0", 15'd2, 32'hA5A5A5A5);
    rd_chk("rx_read_no_pop", 15'd2, 32'hA5A5A5A5);
    wr(15'd2, 32'h0);
    rd_chk("rx_head1", 15'd2, 32'h5A5A5A5A);
    wr(15'd2, 32'h0);
    rd_chk("rx_empty_head", 15'd2, 32'h0);
    rd_chk("err_no_udf", 15'd3, 32'h0);
    wr(15'd2, 32'h0);
    rd_chk("err_rx_udf", 15'd3, 32'h2);
    rd_chk("status_after_udf", 15'd0, 32'h0000000A);
    wr(15'd3, 32'h4);

    // Fill RX and overflow
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.rx_data = 32'h200 + 32'(i);
      tick();
    end
    chk("rx_ready_full", 32'(bus.rx_ready), 32'd0);
    rd_chk("status_rx_full", 15'd0, 32'h00080006);
    bus.rx_data = 32'hBAD;
    tick();
    bus.rx_valid = 1'b0;
    rd_chk("err_rx_ovf", 15'd3, 32'h4);
    rd_chk("status_rx_ovf", 15'd0, 32'h00080006);
    rd_chk("rx_head_ovf", 15'd2, 32'h200);
    wr(15'd3, 32'h2);
    rd_chk("status_rx_flush", 15'd0, 32'h0000000A);
    rd_chk("err_kept_flush", 15'd3, 32'h4);
    wr(15'd3, 32'h4);

    // Five words each, then flush both with a host pop pending
    for (int i = 0; i < 5; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 32'h300 + 32'(i);
      wr(15'd1, 32'h400 + 32'(i));
    end
    bus.rx_valid = 1'b0;
    rd_chk("status_5_5", 15'd0, 32'h00050500);
    bus.tx_ready = 1'b1;
    wr(15'd3, 32'h3);
    bus.tx_ready = 1'b0;
    rd_chk("status_flush_both", 15'd0, 32'h0000000A);
    chk("tx_valid_flush", 32'(bus.tx_valid), 32'd0);
    rd_chk("rx_head_flush", 15'd2, 32'h0);

    // Reset mid-stream
    wr(15'd1, 32'h55);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 32'h66;
    tick();
    bus.rx_valid = 1'b0;
    rd_chk("status_pre_rst", 15'd0, 32'h00010100);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("midrst_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("midrst_tx_data", bus.tx_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    rd_chk("status_post_rst", 15'd0, 32'h0000000A);
    rd_chk("err_post_rst", 15'd3, 32'h0);

    // Addresses outside the window
    wr(15'd5, 32'h77);
    rd_chk("unsel_no_push", 15'd0, 32'h0000000A);
    wr(15'd7, 32'h0);
    rd_chk("unsel_no_err", 15'd3, 32'h0);
    rd_chk("unsel_read0", 15'd4, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
